// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with architectural
// HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//
// Ports:
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   start     in   operation request, accepted only while idle
//   op        in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   op_a      in   rs operand: multiplicand / dividend (sampled with start)
//   op_b      in   rt operand: multiplier / divisor (sampled with start)
//   hi_we     in   MTHI strobe (idle only)
//   lo_we     in   MTLO strobe (idle only)
//   wdata     in   MTHI/MTLO data
//   busy      out  operation in flight (registered)
//   done      out  one-cycle pulse when an operation updates HI/LO
//   div_zero  out  sticky: last completed divide had a zero divisor
//   hi, lo    out  HI/LO registers
//
// Fixed latency: start edge N, PREP at N+1, 32 CALC edges N+2..N+33,
// FIX at N+34 writes HI/LO and pulses done.
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int W     = DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     magb_q;     // multiplicand / divisor magnitude
  logic [2*W-1:0]   acc_q;      // {partial product | remainder, multiplier | quotient}
  logic             qneg_q;     // product / quotient sign
  logic             rneg_q;     // remainder sign
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic             a_neg, b_neg;
  logic [W:0]       mul_sum;
  logic [W:0]       div_shift;
  logic             div_ge;
  logic [W-1:0]     div_sub;
  logic [2*W-1:0]   acc_d;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     hi_d, lo_d;

  // Conditional two's-complement negate. Negating 0x80000000 yields
  // 0x80000000, which is the correct magnitude when read as unsigned.
  function automatic logic [W-1:0] cneg_w(input logic [W-1:0] x, input logic neg);
    logic signed [W-1:0] xs;
    xs = x;
    return neg ? W'(-xs) : x;
  endfunction

  function automatic logic [2*W-1:0] cneg_2w(input logic [2*W-1:0] x, input logic neg);
    logic signed [2*W-1:0] xs;
    xs = x;
    return neg ? (2*W)'(-xs) : x;
  endfunction

  always_comb begin
    // Only the signed ops (op[0]==0) take magnitudes.
    a_neg = ~op_q[0] & a_q[W-1];
    b_neg = ~op_q[0] & b_q[W-1];

    // Multiply step: conditional add into the upper half, then shift right.
    // The carry out of the add becomes the new top bit.
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, magb_q} : {(W+1){1'b0}});

    // Restoring divide step: shift next dividend bit into the remainder
    // (33 bits wide), subtract if it fits. The true difference is below
    // the divisor, so the W-bit wrapped subtraction is exact.
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = (div_shift >= {1'b0, magb_q});
    div_sub   = div_shift[W-1:0] - magb_q;

    if (op_q[1])
      acc_d = {(div_ge ? div_sub : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
    else
      acc_d = {mul_sum, acc_q[W-1:1]};

    // Sign correction applied at FIX.
    prod_fix = cneg_2w(acc_q, qneg_q);
    if (op_q[1]) begin
      if (b_q == '0) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = cneg_w(acc_q[2*W-1:W], rneg_q);
        lo_d = cneg_w(acc_q[W-1:0], qneg_q);
      end
    end else begin
      hi_d = prod_fix[2*W-1:W];
      lo_d = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      magb_q  <= '0;
      acc_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Idle: MTHI/MTLO writes, operand capture on start.
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q    <= op;
            a_q     <= op_a;
            b_q     <= op_b;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        // Prep: magnitudes, result signs, iteration count.
        PREP: begin
          acc_q   <= {{W{1'b0}}, cneg_w(a_q, a_neg)};
          magb_q  <= cneg_w(b_q, b_neg);
          qneg_q  <= a_neg ^ b_neg;
          rneg_q  <= a_neg;
          cnt_q   <= CNT_W'(W);
          state_q <= CALC;
        end
        // Calc: one bit per cycle.
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        // Fix: sign correction, HI/LO write-back, done pulse.
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          if (op_q[1]) dz_q <= (b_q == '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a, op_b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int   checks   = 0;
  int   failures = 0;
  logic exp_dz   = 1'b0;

  mul_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {HI, LO} from plain arithmetic on the operation semantics.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (o)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Launch one operation and follow it to done; returns latency (edges after
  // the start edge) and how many sampled cycles showed busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    tick();
    start = 1'b1; op = o; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    op = 2'($urandom); op_a = $urandom; op_b = $urandom;
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int lat, bc;
    exp = model(o, a, b);
    if (o[1]) exp_dz = (b == 32'd0);
    run_op(o, a, b, lat, bc);
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL %s latency: got %0d expected 34", name, lat);
    end
    checks++;
    if (bc !== 34) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected 34", name, bc);
    end
    checks++;
    if ({hi, lo} !== exp) begin
      failures++;
      $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
    end
    checks++;
    if (div_zero !== exp_dz) begin
      failures++;
      $display("FAIL %s div_zero: got %b expected %b", name, div_zero, exp_dz);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: got %b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; op = '0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
    end
    checks++;
    if ({hi, lo} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo: got %h_%h expected 0", hi, lo);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_multu_max();
    test_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_signed();
    test_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0005);
    test_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    test_op("div_negdiv", 2'd2, 32'h0000_0064, 32'hFFFF_FFF9);
  endtask

  task automatic test_div_zero();
    test_op("divu_zero", 2'd3, 32'h0000_0064, 32'd0);
    test_op("mul_keeps_dz", 2'd1, 32'd9, 32'd9);
    test_op("divu_after_zero", 2'd3, 32'd7, 32'd2);
    test_op("div_zero_signed", 2'd2, 32'h8000_0005, 32'd0);
    test_op("div_clear", 2'd2, 32'h8000_0005, 32'd3);
  endtask

  task automatic test_overflow();
    test_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    test_op("mult_minmin", 2'd0, 32'h8000_0000, 32'h8000_0000);
    test_op("divu_big", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_busy_ignore();
    int n;
    logic [31:0] hi_before;
    tick();
    hi_we = 1'b1; wdata = 32'h5A5A_5A5A;
    tick();
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h5A5A_5A5A) begin
      failures++;
      $display("FAIL mthi_idle: got %h expected 5a5a5a5a", hi);
    end
    hi_before = hi;
    start = 1'b1; op = 2'd1; op_a = 32'd3; op_b = 32'd4;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = 2'd0; op_a = 32'd100; op_b = 32'd200;
    tick();
    start = 1'b0;
    repeat (4) tick();
    hi_we = 1'b1; wdata = 32'h0000_DEAD;
    tick();
    hi_we = 1'b0;
    checks++;
    if (hi !== hi_before) begin
      failures++;
      $display("FAIL mthi_busy: got %h expected %h", hi, hi_before);
    end
    wait_done(n);
    checks++;
    if (n + 10 !== 34) begin
      failures++;
      $display("FAIL busy_ignore latency: got %0d expected 34", n + 10);
    end
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_000C) begin
      failures++;
      $display("FAIL busy_ignore hilo: got %h_%h expected 00000000_0000000c", hi, lo);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL busy_ignore no_queue: got busy,done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_mt_writes();
    int n;
    logic [31:0] hi_before;
    hi_before = hi;
    lo_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    lo_we = 1'b0;
    checks++;
    if ({hi, lo} !== {hi_before, 32'h0000_1234}) begin
      failures++;
      $display("FAIL mtlo: got %h_%h expected %h_00001234", hi, lo, hi_before);
    end
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL mtlo_flags: got done,busy=%b expected 00", {done, busy});
    end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if ({hi, lo} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL mthi_mtlo: got %h_%h expected cafef00d_cafef00d", hi, lo);
    end
    // Start coinciding with MTHI: write lands, FIX overwrites later.
    start = 1'b1; op = 2'd1; op_a = 32'd6; op_b = 32'd7;
    hi_we = 1'b1; wdata = 32'h0000_BEEF;
    tick();
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if ({busy, hi} !== {1'b1, 32'h0000_BEEF}) begin
      failures++;
      $display("FAIL start_mthi: got busy=%b hi=%h expected busy=1 hi=0000beef", busy, hi);
    end
    wait_done(n);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_002A || n !== 34) begin
      failures++;
      $display("FAIL start_mthi result: got %h_%h lat %0d expected 00000000_0000002a lat 34", hi, lo, n);
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    test_op("pre_reset_dz", 2'd3, 32'd5, 32'd0);
    tick();
    start = 1'b1; op = 2'd2; op_a = 32'd1000; op_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      failures++;
      $display("FAIL reset_midop: got busy=%b done=%b dz=%b hi=%h lo=%h expected all 0",
               busy, done, div_zero, hi, lo);
    end
    tick(); tick();
    rstn = 1'b1;
    exp_dz = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_abandon: got %0d done/busy cycles expected 0", pulses);
    end
    test_op("after_reset", 2'd1, 32'd2, 32'd2);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      5: return 32'h8000_0000 | 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      test_op("random", 2'($urandom_range(0, 3)), pick_operand(), pick_operand());
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_mt_writes();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits directly downstream of the register file and consumes its two read-data outputs as operands.
- Radix-2 (one bit per cycle), fixed latency, start/busy/done handshake, so the controller can stall on HI/LO hazards.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported; the parameter fixes the iteration count at DATA_W.

Ports:
- clk  in  1  clock, posedge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while idle.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
- op_a  in  32  rs value (multiplicand / dividend); sampled with start.
- op_b  in  32  rt value (multiplier / divisor); sampled with start.
- hi_we  in  1  MTHI: write wdata into HI.
- lo_we  in  1  MTLO: write wdata into LO.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero  out  1  sticky flag: last completed divide had op_b==0.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (rstn low, any time, asynchronous):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; internal accumulators cleared.
  - An operation in flight is abandoned with no done pulse.
- States: IDLE, PREP, CALC, FIX. busy = (state != IDLE), registered.
- IDLE, start=1 at edge N:
  - Latch op, op_a and op_b; go to PREP.
  - Later changes on op_a, op_b and op are ignored.
- PREP (edge N+1):
  - Signed ops: take magnitudes of the operands; record the result signs.
  - Quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - Load the iteration counter with 32; go to CALC.
- CALC (edges N+2..N+33, 32 iterations):
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing a 32-bit quotient and remainder.
  - Exit to FIX when the counter reaches 0.
- FIX (edge N+34):
  - Apply sign correction (two's-complement negate).
  - Multiply: write HI = product[63:32], LO = product[31:0].
  - Divide: write HI = remainder, LO = quotient.
  - Assert done for exactly the cycle after edge N+34; return to IDLE. busy deasserts at that same edge.
- Total latency: start edge to HI/LO valid = 34 cycles. Latency is fixed and does not depend on data.
- Divide by zero:
  - Latency is unchanged. Result is HI = latched op_a and LO = 32'hFFFFFFFF for both DIV and DIVU, with no sign correction.
  - div_zero is set at FIX. It is cleared at the FIX of the next divide with nonzero divisor; multiplies leave it unchanged.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. The magnitude path naturally produces this; no special case and no exception.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned. The datapath must be 33-bit safe for this case.
- start while busy: ignored (no queuing, no error). The in-flight operation is unaffected.
- hi_we / lo_we:
  - While idle, the write takes effect at that edge and is visible next cycle; both may be asserted together.
  - While busy, writes are ignored.
  - If start and hi_we/lo_we coincide in IDLE, the write is applied; start is also accepted, and its FIX later overwrites HI/LO.
- done is never asserted by MTHI/MTLO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge N -> busy=1 over edges N..N+34, done pulse after N+34, HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_zero=0.
- DIVU 0x00000064 / 0 -> after 34 cycles HI=0x00000064, LO=0xFFFFFFFF, div_zero=1. Next DIVU 7/2 -> LO=3, HI=1, div_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, no flag.
- Start MULTU 3x4, pulse start again with different operands at cycle 5, and assert hi_we with wdata=0xDEAD at cycle 10 -> both ignored; HI=0, LO=0x0000000C. Then, idle, lo_we with wdata=0x1234 -> LO=0x1234 next cycle, no done.
- Start DIV, drop rstn at cycle 10 for 2 cycles -> busy=0, HI=LO=0, done never pulses. A new MULTU 2x2 afterwards -> LO=4 after 34 cycles.
